// File: rtl/npu_loop_seq.sv
// npu_loop_seq: layer loop sequencer for the NPU PE array.
// Latches one array-reload configuration on start, then walks the
// nested loop ofmap > ifmap > input tile > kernel tap, closing every
// ofmap with a write-back burst of o_tile+1 cycles.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             run request, honoured in IDLE only
//   c1_c2_n, arv_*    layer select and loop limits from the config block
//   stall             datapath back-pressure, freezes RUN/WB
//   busy, done        layer in flight / one-cycle end-of-layer pulse
//   layer_c1_c2_n     latched layer select
//   ckgate            latched active column count
//   k_idx..ofm_idx    loop indices for address generation
//   acc_en, acc_clr   PE accumulate strobe and first-accumulation flag
//   wb_en, wb_tile    write-back strobe and output tile index

module npu_loop_seq #(
    parameter int CLOG2K = 3,
    parameter int CLOG2W = 5,
    parameter int CLOG2T = 4,
    parameter int CLOG2B = 4,
    parameter int CLOG2C = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              c1_c2_n,
    input  logic [CLOG2K-1:0] arv_ksize,
    input  logic [CLOG2W-1:0] arv_ckgate,
    input  logic [CLOG2T-1:0] arv_i_tile,
    input  logic [CLOG2T-1:0] arv_o_tile,
    input  logic [CLOG2B-1:0] arv_ifmaps,
    input  logic [CLOG2C-1:0] arv_ofmaps,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              layer_c1_c2_n,
    output logic [CLOG2W-1:0] ckgate,
    output logic [CLOG2K-1:0] k_idx,
    output logic [CLOG2T-1:0] tile_idx,
    output logic [CLOG2B-1:0] ifm_idx,
    output logic [CLOG2C-1:0] ofm_idx,
    output logic              acc_en,
    output logic              acc_clr,
    output logic              wb_en,
    output logic [CLOG2T-1:0] wb_tile
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [CLOG2K-1:0] K_ONE = 1;
    localparam logic [CLOG2T-1:0] T_ONE = 1;
    localparam logic [CLOG2B-1:0] B_ONE = 1;
    localparam logic [CLOG2C-1:0] C_ONE = 1;

    state_e state_q, state_d;

    // Shadow copy of the configuration, frozen for the whole layer
    logic [CLOG2K-1:0] lim_k_q;
    logic [CLOG2T-1:0] lim_it_q;
    logic [CLOG2T-1:0] lim_ot_q;
    logic [CLOG2B-1:0] lim_ifm_q;
    logic [CLOG2C-1:0] lim_ofm_q;
    logic [CLOG2W-1:0] ckgate_q;
    logic              layer_q;
    logic              cfg_ld;

    // Loop counters
    logic [CLOG2K-1:0] k_q, k_d;
    logic [CLOG2T-1:0] tile_q, tile_d;
    logic [CLOG2B-1:0] ifm_q, ifm_d;
    logic [CLOG2C-1:0] ofm_q, ofm_d;
    logic [CLOG2T-1:0] wbt_q, wbt_d;

    logic last_k, last_t, last_i, last_o, last_w;
    logic run_go, wb_go;

    assign last_k = (k_q == lim_k_q);
    assign last_t = (tile_q == lim_it_q);
    assign last_i = (ifm_q == lim_ifm_q);
    assign last_o = (ofm_q == lim_ofm_q);
    assign last_w = (wbt_q == lim_ot_q);

    assign run_go = (state_q == S_RUN) && !stall;
    assign wb_go  = (state_q == S_WB) && !stall;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tile_d  = tile_q;
        ifm_d   = ifm_q;
        ofm_d   = ofm_q;
        wbt_d   = wbt_q;
        cfg_ld  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_ld  = 1'b1;
                    k_d     = '0;
                    tile_d  = '0;
                    ifm_d   = '0;
                    ofm_d   = '0;
                    wbt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Ripple increment: k -> tile -> ifm, each wrapping
                // to zero once it has reached its limit.
                if (run_go) begin
                    if (!last_k) begin
                        k_d = k_q + K_ONE;
                    end else begin
                        k_d = '0;
                        if (!last_t) begin
                            tile_d = tile_q + T_ONE;
                        end else begin
                            tile_d = '0;
                            if (!last_i) begin
                                ifm_d = ifm_q + B_ONE;
                            end else begin
                                ifm_d   = '0;
                                state_d = S_WB;
                            end
                        end
                    end
                end
            end
            S_WB: begin
                if (wb_go) begin
                    if (!last_w) begin
                        wbt_d = wbt_q + T_ONE;
                    end else begin
                        wbt_d = '0;
                        if (last_o) begin
                            state_d = S_DONE;
                        end else begin
                            ofm_d   = ofm_q + C_ONE;
                            state_d = S_RUN;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            tile_q    <= '0;
            ifm_q     <= '0;
            ofm_q     <= '0;
            wbt_q     <= '0;
            lim_k_q   <= '0;
            lim_it_q  <= '0;
            lim_ot_q  <= '0;
            lim_ifm_q <= '0;
            lim_ofm_q <= '0;
            ckgate_q  <= '0;
            layer_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tile_q  <= tile_d;
            ifm_q   <= ifm_d;
            ofm_q   <= ofm_d;
            wbt_q   <= wbt_d;
            if (cfg_ld) begin
                lim_k_q   <= arv_ksize;
                lim_it_q  <= arv_i_tile;
                lim_ot_q  <= arv_o_tile;
                lim_ifm_q <= arv_ifmaps;
                lim_ofm_q <= arv_ofmaps;
                ckgate_q  <= arv_ckgate;
                layer_q   <= c1_c2_n;
            end
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign layer_c1_c2_n = layer_q;
    assign ckgate        = ckgate_q;
    assign k_idx         = k_q;
    assign tile_idx      = tile_q;
    assign ifm_idx       = ifm_q;
    assign ofm_idx       = ofm_q;
    assign acc_en        = run_go;
    // First accumulation of an ofmap: every tile at ifmap 0, tap 0
    assign acc_clr       = run_go && (ifm_q == '0) && (k_q == '0);
    assign wb_en         = wb_go;
    assign wb_tile       = wbt_q;

endmodule

// File: tb/tb_npu_loop_seq.sv
// tb_npu_loop_seq: randomized bench for npu_loop_seq against a
// trace-queue model of the layer loop nest.

module tb_npu_loop_seq;

    localparam int CK = 3;
    localparam int CW = 5;
    localparam int CT = 4;
    localparam int CB = 4;
    localparam int CC = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          c1_c2_n = 1'b0;
    logic          stall = 1'b0;
    logic [CK-1:0] arv_ksize = '0;
    logic [CW-1:0] arv_ckgate = '0;
    logic [CT-1:0] arv_i_tile = '0;
    logic [CT-1:0] arv_o_tile = '0;
    logic [CB-1:0] arv_ifmaps = '0;
    logic [CC-1:0] arv_ofmaps = '0;

    logic          busy, done, layer_c1_c2_n;
    logic [CW-1:0] ckgate;
    logic [CK-1:0] k_idx;
    logic [CT-1:0] tile_idx;
    logic [CB-1:0] ifm_idx;
    logic [CC-1:0] ofm_idx;
    logic          acc_en, acc_clr, wb_en;
    logic [CT-1:0] wb_tile;

    npu_loop_seq #(
        .CLOG2K(CK), .CLOG2W(CW), .CLOG2T(CT),
        .CLOG2B(CB), .CLOG2C(CC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .c1_c2_n(c1_c2_n),
        .arv_ksize(arv_ksize), .arv_ckgate(arv_ckgate),
        .arv_i_tile(arv_i_tile), .arv_o_tile(arv_o_tile),
        .arv_ifmaps(arv_ifmaps), .arv_ofmaps(arv_ofmaps),
        .stall(stall), .busy(busy), .done(done),
        .layer_c1_c2_n(layer_c1_c2_n), .ckgate(ckgate),
        .k_idx(k_idx), .tile_idx(tile_idx), .ifm_idx(ifm_idx),
        .ofm_idx(ofm_idx), .acc_en(acc_en), .acc_clr(acc_clr),
        .wb_en(wb_en), .wb_tile(wb_tile)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: on acceptance, the whole layer is unrolled into a list of
    // expected cycles. A stalled RUN/WB cycle keeps the head in place.
    localparam int E_ACC = 0;
    localparam int E_WB  = 1;
    localparam int E_DN  = 2;

    typedef struct {
        int kind;
        int k;
        int t;
        int i;
        int o;
        int w;
    } ent_t;

    ent_t mq[$];
    ent_t hold;
    int   m_ck = 0;
    int   m_ly = 0;
    bit   m_valid = 0;

    task automatic build(input int lk, input int lt, input int li,
                         input int lo, input int lw);
        for (int o = 0; o <= lo; o++) begin
            for (int i = 0; i <= li; i++)
                for (int t = 0; t <= lt; t++)
                    for (int k = 0; k <= lk; k++)
                        mq.push_back('{E_ACC, k, t, i, o, 0});
            for (int w = 0; w <= lw; w++)
                mq.push_back('{E_WB, 0, 0, 0, o, w});
        end
        mq.push_back('{E_DN, 0, 0, 0, lo, 0});
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            hold = '{0, 0, 0, 0, 0, 0};
            m_ck = 0;
            m_ly = 0;
            m_valid = 1;
        end else if (m_valid) begin
            if (mq.size() == 0) begin
                if (start) begin
                    m_ck = int'(arv_ckgate);
                    m_ly = int'(c1_c2_n);
                    build(int'(arv_ksize), int'(arv_i_tile),
                          int'(arv_ifmaps), int'(arv_ofmaps),
                          int'(arv_o_tile));
                end
            end else if (mq[0].kind == E_DN) begin
                hold = mq[0];
                void'(mq.pop_front());
            end else if (!stall) begin
                void'(mq.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    always @(negedge clk) begin : cmp
        ent_t e;
        bit eb, ed, ea, ec, ew;
        if (m_valid) begin
            if (mq.size() != 0) begin
                e  = mq[0];
                eb = 1;
                ed = (e.kind == E_DN);
                ea = (e.kind == E_ACC) && !stall;
                ew = (e.kind == E_WB) && !stall;
                ec = ea && (e.i == 0) && (e.k == 0);
            end else begin
                e   = hold;
                e.w = 0;
                eb  = 0;
                ed  = 0;
                ea  = 0;
                ew  = 0;
                ec  = 0;
            end
            chk("busy", busy, eb);
            chk("done", done, ed);
            chk("acc_en", acc_en, ea);
            chk("acc_clr", acc_clr, ec);
            chk("wb_en", wb_en, ew);
            chk("wb_tile", wb_tile, e.w);
            chk("k_idx", k_idx, e.k);
            chk("tile_idx", tile_idx, e.t);
            chk("ifm_idx", ifm_idx, e.i);
            chk("ofm_idx", ofm_idx, e.o);
            chk("ckgate", ckgate, m_ck);
            chk("layer", layer_c1_c2_n, m_ly);
        end
    end

    task automatic run_layer(
        input int lk, input int lt, input int li, input int lo,
        input int lw, input int ck, input bit ly,
        input int st_at, input int st_len, input bit rnd,
        input int dup_at, input int rst_at,
        output int cyc, output int n_clr, output int n_wb,
        output bit aborted);
        cyc = -1;
        n_clr = 0;
        n_wb = 0;
        aborted = 0;
        @(posedge clk);
        #1;
        arv_ksize  = CK'(lk);
        arv_i_tile = CT'(lt);
        arv_ifmaps = CB'(li);
        arv_ofmaps = CC'(lo);
        arv_o_tile = CT'(lw);
        arv_ckgate = CW'(ck);
        c1_c2_n    = ly;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        // Config changes after acceptance must not matter
        arv_ksize  = CK'($urandom);
        arv_i_tile = CT'($urandom);
        arv_ifmaps = CB'($urandom);
        arv_ofmaps = CC'($urandom);
        arv_o_tile = CT'($urandom);
        arv_ckgate = CW'($urandom);
        c1_c2_n    = ~ly;
        for (int c = 1; c <= 3000; c++) begin
            stall = ((c >= st_at) && (c < st_at + st_len)) ||
                    (rnd && ($urandom_range(0, 3) == 0));
            if (c == dup_at)
                start = 1'b1;
            else if (rnd)
                start = 1'($urandom_range(0, 1));
            else
                start = 1'b0;
            if (c == rst_at) rst = 1'b1;
            @(negedge clk);
            if (acc_clr) n_clr++;
            if (wb_en) n_wb++;
            if (done) begin
                cyc = c;
                break;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
                aborted = 1;
                break;
            end
        end
        if (!aborted) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    initial begin : wdog
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n_clr, n_wb, d0;
        bit ab;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_ckgate", ckgate, 0);

        // Minimal layer: RUN, WB, DONE
        d0 = done_cnt;
        run_layer(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0,
                  cyc, n_clr, n_wb, ab);
        chk("min_cycles", cyc, 3);
        chk("min_clr", n_clr, 1);
        chk("min_wb", n_wb, 1);
        @(negedge clk);
        chk("min_busy_after", busy, 0);
        chk("min_done_cnt", done_cnt - d0, 1);

        // Nested layer with a second start at cycle 5
        d0 = done_cnt;
        run_layer(2, 1, 1, 1, 1, 7, 1, 0, 0, 0, 5, 0,
                  cyc, n_clr, n_wb, ab);
        chk("nest_cycles", cyc, 29);
        chk("nest_clr", n_clr, 4);
        chk("nest_wb", n_wb, 4);
        repeat (3) @(negedge clk);
        chk("nest_done_cnt", done_cnt - d0, 1);

        // Stall for 3 cycles from RUN cycle 2
        run_layer(1, 0, 0, 0, 0, 0, 0, 2, 3, 0, 0, 0,
                  cyc, n_clr, n_wb, ab);
        chk("stall_cycles", cyc, 7);
        chk("stall_clr", n_clr, 1);

        // Reset mid-layer, then a full rerun
        d0 = done_cnt;
        run_layer(2, 1, 1, 1, 1, 7, 1, 0, 0, 0, 0, 10,
                  cyc, n_clr, n_wb, ab);
        chk("abort_flag", ab, 1);
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_ckgate", ckgate, 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        run_layer(2, 1, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0,
                  cyc, n_clr, n_wb, ab);
        chk("rerun_cycles", cyc, 29);

        // Boundary limits
        run_layer(7, 0, 0, 0, 15, 31, 0, 0, 0, 0, 0, 0,
                  cyc, n_clr, n_wb, ab);
        chk("maxk_cycles", cyc, 25);
        chk("maxk_wb", n_wb, 16);
        run_layer(0, 0, 0, 31, 0, 1, 1, 0, 0, 0, 0, 0,
                  cyc, n_clr, n_wb, ab);
        chk("maxo_cycles", cyc, 65);
        run_layer(0, 15, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0,
                  cyc, n_clr, n_wb, ab);
        chk("maxt_cycles", cyc, 18);
        chk("maxt_clr", n_clr, 16);

        // Random layers with random stall and stray starts
        for (int n = 0; n < 25; n++) begin
            d0 = done_cnt;
            run_layer($urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 31),
                      1'($urandom_range(0, 1)), 0, 0, 1, 0, 0,
                      cyc, n_clr, n_wb, ab);
            chk("rnd_finished", (cyc > 0) ? 1 : 0, 1);
            repeat (2) @(negedge clk);
            chk("rnd_done_cnt", done_cnt - d0, 1);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/npu_loop_seq.md
Name: npu_loop_seq

Overview:
- Consumer of the array-reload configuration words (ksize, ckgate, i_tile, o_tile, ifmaps, ofmaps) that the configuration block produces per layer.
- Latches one configuration on a start request, then sequences the nested convolution loop: ofmap > ifmap > tile > kernel tap.
- Each ofmap iteration ends with a write-back phase.
- Drives the PE-array accumulate/clear/write-back strobes and the loop indices for address generation. Sits between the configuration block and the NPU datapath.

Parameters:
- CLOG2K, 3, width of the kernel-tap limit/index
- CLOG2W, 5, width of the clock-gate column count
- CLOG2T, 4, width of the i_tile/o_tile limits and indices
- CLOG2B, 4, width of the ifmap limit/index
- CLOG2C, 5, width of the ofmap limit/index

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request to run one layer; sampled in IDLE only
- c1_c2_n  in  1  layer select, latched with config, echoed on layer_c1_c2_n
- arv_ksize  in  CLOG2K  last kernel-tap index (taps = value+1)
- arv_ckgate  in  CLOG2W  active column count for clock gating
- arv_i_tile  in  CLOG2T  last input-tile index
- arv_o_tile  in  CLOG2T  last output-tile index (write-back length-1)
- arv_ifmaps  in  CLOG2B  last ifmap index
- arv_ofmaps  in  CLOG2C  last ofmap index
- stall  in  1  datapath not ready; freezes sequencing in RUN/WB
- busy  out  1  high from the cycle after start acceptance until done inclusive
- done  out  1  one-cycle pulse at layer end
- layer_c1_c2_n  out  1  latched c1_c2_n
- ckgate  out  CLOG2W  latched arv_ckgate, constant while busy
- k_idx  out  CLOG2K  current kernel tap
- tile_idx  out  CLOG2T  current input tile
- ifm_idx  out  CLOG2B  current ifmap
- ofm_idx  out  CLOG2C  current ofmap
- acc_en  out  1  accumulate this cycle
- acc_clr  out  1  accumulator clear qualifier (first accumulation of an ofmap)
- wb_en  out  1  write-back strobe
- wb_tile  out  CLOG2T  write-back tile index

Behaviour:
- Reset: state IDLE. All outputs and latched config cleared to 0; counters cleared.
- States: IDLE, RUN, WB, DONE.
- IDLE:
  - start=1 latches all arv_* and c1_c2_n into shadow registers, clears counters, and moves to RUN next cycle.
  - Input changes after acceptance have no effect.
- RUN: acc_en=1 when stall=0. Indices count up from 0. Each non-stalled cycle performs a ripple increment:
  - k_idx wraps at lim_k and carries into tile_idx.
  - tile_idx wraps at lim_i_tile and carries into ifm_idx.
  - When k, tile and ifm are all at their limits, the next state is WB and ifm_idx/tile_idx/k_idx return to 0.
- acc_clr=1 exactly when acc_en=1 and ifm_idx=0 and k_idx=0 (any tile).
- WB:
  - wb_en=1 when stall=0. wb_tile counts 0..lim_o_tile.
  - At the last non-stalled cycle with wb_tile=lim_o_tile: if ofm_idx=lim_ofm go to DONE, else increment ofm_idx and return to RUN.
  - wb_tile is reset to 0 on exit.
- DONE: done=1, busy=1 for one cycle, then IDLE. Indices hold their final values until the next start.
- stall=1 in RUN or WB:
  - acc_en, acc_clr and wb_en are forced to 0.
  - All counters and state hold.
  - stall has no effect in IDLE or DONE.
- Cycle count with no stall: N = (lim_ofm+1)*((lim_ifm+1)*(lim_i_tile+1)*(lim_k+1) + (lim_o_tile+1)). done is asserted N+1 cycles after the start-accept edge.
- Limits of 0 are legal: one iteration each.
- Counters never exceed their limits. No arithmetic overflow is possible, because a counter compares equal to its limit before it wraps.
- start while busy: ignored, not queued.
- start in the same cycle as done: ignored, because the FSM is in DONE, not IDLE.
- rst mid-layer: returns to IDLE next edge with all outputs 0; done is not pulsed.
- ckgate and layer_c1_c2_n are registered outputs of the shadow registers, valid from the first RUN cycle.

Test Plan:
- Reset then idle: rst 2 cycles, start=0 for 10 cycles -> all outputs 0, busy=0.
- Minimal layer:
  - Stimulus: all arv_*=0, start pulse.
  - Cycle 1: RUN, acc_en=1, acc_clr=1.
  - Cycle 2: wb_en=1, wb_tile=0.
  - Cycle 3: done=1.
  - Cycle 4: busy=0.
- Nested layer:
  - Stimulus: ksize=2, i_tile=1, ifmaps=1, ofmaps=1, o_tile=1, ckgate=7, c1_c2_n=1.
  - Required: 2*(12+2)=28 RUN/WB cycles; done at cycle 29.
  - acc_clr high on 2 cycles per ofmap (ifm=0, k=0, tiles 0 and 1).
  - wb_tile sequence 0,1 per ofmap.
  - ckgate=7 throughout.
- Stall:
  - Stimulus: same config as the minimal layer with ksize=1, stall=1 for 3 cycles at RUN cycle 2.
  - Required: indices frozen, acc_en=0 during the stall; done delayed by exactly 3 cycles.
- start while busy and rst mid-layer:
  - A second start at cycle 5 is ignored; done count stays 1.
  - rst at cycle 10 of the nested layer forces IDLE with outputs 0 next cycle and no done pulse.
  - A new start afterwards runs the full 28-cycle sequence.
